store_buffer: RTL and testbench

Four-entry posted-write FIFO that sits directly upstream of the data memory. Retired stores from the MEM stage are accepted in one cycle and drained to the data-memory write port one per cycle whenever that port is not busy serving a load. Loads look up the buffer combinationally so that a load always returns the youngest value stored to its word address, whether or not that store has reached memory yet.

---
 rtl/store_buffer_if.sv | 34 +++
 rtl/store_buffer.sv | 119 +++++++++++
 tb/tb_store_buffer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store buffer bundle: MEM-stage store request, load lookup and data-memory write port.
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [31:0]   st_pc;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [31:0]   ld_data;
    logic          dm_busy;
    logic [AW-1:0] dm_A;
    logic [31:0]   dm_WData;
    logic [31:0]   dm_PC;
    logic          dm_MemWrite;
    logic [CW-1:0] count;
    logic          empty;

    modport master (
        output st_valid, st_addr, st_data, st_pc, ld_valid, ld_addr, dm_busy,
        input  st_ready, ld_hit, ld_data, dm_A, dm_WData, dm_PC, dm_MemWrite, count, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_pc, ld_valid, ld_addr, dm_busy,
        output st_ready, ld_hit, ld_data, dm_A, dm_WData, dm_PC, dm_MemWrite, count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO in front of data memory; drains one store per free memory cycle
// and forwards the youngest buffered value for a load address.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_r [DEPTH];
    logic [31:0]      data_r [DEPTH];
    logic [31:0]      pc_r   [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;

    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic          hit_s;
    logic [31:0]   hit_data_s;
    logic [PW-1:0] idx_s;

    // Occupancy flags come from registered count only, so a same-cycle pop never frees a slot.
    assign empty_s = (count_r == {CW{1'b0}});
    assign full_s  = (count_r == CW'(DEPTH));
    assign push_s  = bus.st_valid && !full_s;
    assign pop_s   = !empty_s && !bus.dm_busy;

    // Youngest-first lookup: walk oldest to youngest so later matches override earlier ones.
    always_comb begin
        hit_s      = 1'b0;
        hit_data_s = 32'h0000_0000;
        idx_s      = head_r;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head_r + PW'(i);
            if (valid_r[idx_s] && (addr_r[idx_s] == bus.ld_addr)) begin
                hit_s      = 1'b1;
                hit_data_s = data_r[idx_s];
            end else begin
                hit_s      = hit_s;
                hit_data_s = hit_data_s;
            end
        end
        if (!bus.ld_valid) begin
            hit_s      = 1'b0;
            hit_data_s = 32'h0000_0000;
        end else begin
            hit_s      = hit_s;
            hit_data_s = hit_data_s;
        end
    end

    // Entry storage and valid bits; pop clears the head, push fills the tail.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= {AW{1'b0}};
                data_r[i] <= 32'h0000_0000;
                pc_r[i]   <= 32'h0000_0000;
            end
            valid_r <= {DEPTH{1'b0}};
        end else begin
            if (pop_s) begin
                valid_r[head_r] <= 1'b0;
            end
            if (push_s) begin
                addr_r[tail_r]  <= bus.st_addr;
                data_r[tail_r]  <= bus.st_data;
                pc_r[tail_r]    <= bus.st_pc;
                valid_r[tail_r] <= 1'b1;
            end
        end
    end

    // Head/tail pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r <= {PW{1'b0}};
            tail_r <= {PW{1'b0}};
        end else begin
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            if (push_s) begin
                tail_r <= tail_r + PW'(1);
            end
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign bus.st_ready    = !full_s;
    assign bus.empty       = empty_s;
    assign bus.count       = count_r;
    assign bus.dm_MemWrite = pop_s;
    assign bus.dm_A        = addr_r[head_r];
    assign bus.dm_WData    = data_r[head_r];
    assign bus.dm_PC       = pc_r[head_r];
    assign bus.ld_hit      = hit_s;
    assign bus.ld_data     = hit_data_s;
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed stores queue expected memory writes,
// a negedge monitor checks every write the buffer issues.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 10;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [31:0]   pc;
    } wr_t;

    logic clk;
    logic reset;
    int   checks;
    int   passes;
    wr_t  exp_q[$];

    store_buffer_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one store for one cycle; the caller guarantees it will be accepted.
    task automatic store(input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] p);
        wr_t e;
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.st_pc    = p;
        e.addr = a;
        e.data = d;
        e.pc   = p;
        exp_q.push_back(e);
        tick();
        bus.st_valid = 1'b0;
    endtask

    task automatic lookup(input logic [AW-1:0] a, input logic hit, input logic [31:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        #1;
        check("ld_hit", 32'(bus.ld_hit), 32'(hit));
        check("ld_data", bus.ld_data, d);
        bus.ld_valid = 1'b0;
    endtask

    // Monitor: every memory write must match the oldest outstanding expected store.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.dm_MemWrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: addr %h data %h, expected no write",
                             bus.dm_A, bus.dm_WData);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.dm_A), 32'(e.addr));
                    check("wr_data", bus.dm_WData, e.data);
                    check("wr_pc", bus.dm_PC, e.pc);
                end
            end
        end
    end

    initial begin
        checks       = 0;
        passes       = 0;
        reset        = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = 32'h0;
        bus.st_pc    = 32'h0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.dm_busy  = 1'b0;
        #1;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_st_ready", 32'(bus.st_ready), 32'd1);
        check("rst_memwrite", 32'(bus.dm_MemWrite), 32'd0);
        check("rst_ld_hit", 32'(bus.ld_hit), 32'd0);
        check("rst_ld_data", bus.ld_data, 32'h0);
        check("rst_dm_A", 32'(bus.dm_A), 32'd0);
        check("rst_dm_WData", bus.dm_WData, 32'h0);
        check("rst_dm_PC", bus.dm_PC, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Single store drains on the next cycle.
        store(10'h010, 32'hDEAD_BEEF, 32'h0000_0100);
        #1;
        check("single_memwrite", 32'(bus.dm_MemWrite), 32'd1);
        check("single_dm_A", 32'(bus.dm_A), 32'h010);
        check("single_dm_WData", bus.dm_WData, 32'hDEAD_BEEF);
        check("single_count", 32'(bus.count), 32'd1);
        lookup(10'h010, 1'b1, 32'hDEAD_BEEF);
        tick();
        #1;
        check("single_empty", 32'(bus.empty), 32'd1);
        check("single_count0", 32'(bus.count), 32'd0);

        // Fill while memory is busy, fifth store is refused, then drain in order.
        bus.dm_busy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            store(AW'(k), 32'hA000_0000 + 32'(k), 32'h0000_0200 + 32'(4 * k));
        end
        #1;
        check("fill_count", 32'(bus.count), 32'd4);
        check("fill_st_ready", 32'(bus.st_ready), 32'd0);
        check("fill_memwrite", 32'(bus.dm_MemWrite), 32'd0);
        bus.st_valid = 1'b1;
        bus.st_addr  = 10'h005;
        bus.st_data  = 32'h0000_0BAD;
        bus.st_pc    = 32'h0000_0300;
        tick();
        bus.st_valid = 1'b0;
        #1;
        check("fifth_ignored_count", 32'(bus.count), 32'd4);
        lookup(10'h003, 1'b1, 32'hA000_0003);
        bus.dm_busy = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            tick();
            #1;
            check("drain_count", 32'(bus.count), 32'(k));
        end
        check("drain_empty", 32'(bus.empty), 32'd1);

        // Youngest match wins; a store pushed this cycle is not yet visible.
        bus.dm_busy = 1'b1;
        store(10'h005, 32'h1111_1111, 32'h0000_0400);
        store(10'h005, 32'h2222_2222, 32'h0000_0404);
        lookup(10'h005, 1'b1, 32'h2222_2222);
        lookup(10'h006, 1'b0, 32'h0);
        bus.st_valid = 1'b1;
        bus.st_addr  = 10'h006;
        bus.st_data  = 32'h3333_3333;
        bus.st_pc    = 32'h0000_0408;
        lookup(10'h006, 1'b0, 32'h0);
        exp_q.push_back('{addr: 10'h006, data: 32'h3333_3333, pc: 32'h0000_0408});
        tick();
        bus.st_valid = 1'b0;
        lookup(10'h006, 1'b1, 32'h3333_3333);
        bus.ld_addr = 10'h005;
        #1;
        check("ld_valid_low_hit", 32'(bus.ld_hit), 32'd0);
        check("ld_valid_low_data", bus.ld_data, 32'h0);
        bus.dm_busy = 1'b0;
        repeat (3) tick();
        #1;
        check("fwd_drain_empty", 32'(bus.empty), 32'd1);

        // Steady push+pop at count 2, wrapping both pointers.
        bus.dm_busy = 1'b1;
        store(10'h020, 32'hB000_0000, 32'h0000_0500);
        store(10'h021, 32'hB000_0001, 32'h0000_0504);
        bus.dm_busy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.st_valid = 1'b1;
            bus.st_addr  = AW'(32'h30 + 32'(k));
            bus.st_data  = 32'hC000_0000 + 32'(k);
            bus.st_pc    = 32'h0000_0600 + 32'(4 * k);
            exp_q.push_back('{addr: AW'(32'h30 + 32'(k)), data: 32'hC000_0000 + 32'(k),
                              pc: 32'h0000_0600 + 32'(4 * k)});
            tick();
            #1;
            check("pushpop_count", 32'(bus.count), 32'd2);
        end
        bus.st_valid = 1'b0;
        repeat (2) tick();
        #1;
        check("pushpop_empty", 32'(bus.empty), 32'd1);

        // Full with a pop in the same cycle: the store waits one cycle.
        bus.dm_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            store(AW'(32'h40 + 32'(k)), 32'hD000_0000 + 32'(k), 32'h0000_0700 + 32'(4 * k));
        end
        bus.dm_busy  = 1'b0;
        bus.st_valid = 1'b1;
        bus.st_addr  = 10'h050;
        bus.st_data  = 32'hE000_0050;
        bus.st_pc    = 32'h0000_0800;
        #1;
        check("fullpop_st_ready", 32'(bus.st_ready), 32'd0);
        tick();
        #1;
        check("fullpop_count3", 32'(bus.count), 32'd3);
        check("fullpop_st_ready1", 32'(bus.st_ready), 32'd1);
        exp_q.push_back('{addr: 10'h050, data: 32'hE000_0050, pc: 32'h0000_0800});
        tick();
        bus.st_valid = 1'b0;
        #1;
        check("fullpop_accept_count", 32'(bus.count), 32'd3);
        repeat (3) tick();
        #1;
        check("fullpop_empty", 32'(bus.empty), 32'd1);

        // Asynchronous reset with three pending stores discards them all.
        bus.dm_busy = 1'b1;
        store(10'h060, 32'hF000_0000, 32'h0000_0900);
        store(10'h061, 32'hF000_0001, 32'h0000_0904);
        store(10'h062, 32'hF000_0002, 32'h0000_0908);
        bus.dm_busy = 1'b0;
        #1;
        check("prereset_memwrite", 32'(bus.dm_MemWrite), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("areset_memwrite", 32'(bus.dm_MemWrite), 32'd0);
        check("areset_count", 32'(bus.count), 32'd0);
        check("areset_empty", 32'(bus.empty), 32'd1);
        check("areset_dm_A", 32'(bus.dm_A), 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        #1;
        check("postreset_empty", 32'(bus.empty), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
